// File: rtl/lc3_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_ctrl_pkg
//  Purpose  : Opcodes, sequencer states and memory-phase encodings for the
//             LC-3 pipeline controller.
//  Revision : 1.0  initial release
// ============================================================================
package lc3_ctrl_pkg;

    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_MEM  = 2'd1,
        ST_CTRL = 2'd2
    } ctrl_state_t;

    typedef enum logic [1:0] {
        MS_READ  = 2'd0,
        MS_IND   = 2'd1,
        MS_WRITE = 2'd2,
        MS_IDLE  = 2'd3
    } mem_state_t;

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == OP_LD)  || (op == OP_LDR) || (op == OP_LDI) ||
               (op == OP_ST)  || (op == OP_STR) || (op == OP_STI);
    endfunction

    // Indirect forms spend their first phase fetching the effective address.
    function automatic mem_state_t first_mem_state(input logic [3:0] op);
        case (op)
            OP_LD, OP_LDR:  return MS_READ;
            OP_ST, OP_STR:  return MS_WRITE;
            OP_LDI, OP_STI: return MS_IND;
            default:        return MS_IDLE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lc3_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_hazard_detect
//  Purpose  : Combinational operand-bypass selects from the decode and
//             execute instructions.
//  Revision : 1.0  initial release
// ============================================================================
module lc3_hazard_detect
    import lc3_ctrl_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [15:0] ir_exec,
    input  logic        active,
    output logic        bypass_alu_1,
    output logic        bypass_alu_2,
    output logic        bypass_mem_1,
    output logic        bypass_mem_2
);

    logic w_use_sr1;
    logic w_use_sr2;
    logic w_alu_src;
    logic w_mem_src;
    logic w_hit_1;
    logic w_hit_2;
    logic w_unused_bits;

    always_comb begin
        w_use_sr1 = 1'b0;
        w_use_sr2 = 1'b0;
        case (ir[15:12])
            OP_ADD, OP_AND: begin
                w_use_sr1 = 1'b1;
                w_use_sr2 = ~ir[5];
            end
            OP_NOT, OP_LDR, OP_STR, OP_JMP: w_use_sr1 = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_alu_src = 1'b0;
        w_mem_src = 1'b0;
        case (ir_exec[15:12])
            OP_ADD, OP_AND, OP_NOT, OP_LEA: w_alu_src = 1'b1;
            OP_LD, OP_LDR, OP_LDI:          w_mem_src = 1'b1;
            default: ;
        endcase
    end

    assign w_hit_1 = active & w_use_sr1 & (ir[8:6] == ir_exec[11:9]);
    assign w_hit_2 = active & w_use_sr2 & (ir[2:0] == ir_exec[11:9]);

    assign bypass_alu_1 = w_hit_1 & w_alu_src;
    assign bypass_alu_2 = w_hit_2 & w_alu_src;
    assign bypass_mem_1 = w_hit_1 & w_mem_src;
    assign bypass_mem_2 = w_hit_2 & w_mem_src;

    assign w_unused_bits = ^{ir[11:9], ir[4:3], ir_exec[8:0]};

endmodule
`default_nettype wire

// File: rtl/lc3_pipe_controller.sv
`default_nettype none
// ============================================================================
//  Module   : lc3_pipe_controller
//  Purpose  : LC-3 pipeline sequencer: stage enables, memory/control stalls,
//             branch resolution and bypass selects.
//             Define LC3_CTRL_STALL_CNT_EN to add the stall_count output.
//  Revision : 1.0  initial release
// ============================================================================
module lc3_pipe_controller
    import lc3_ctrl_pkg::*;
#(
    parameter int CTRL_WAIT = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             complete_instr,
    input  logic             complete_data,
    input  logic [15:0]      IMem_dout,
    input  logic [15:0]      IR,
    input  logic [15:0]      IR_Exec,
    input  logic [2:0]       NZP,
    input  logic [2:0]       psr,
    output logic             enable_fetch,
    output logic             enable_decode,
    output logic             enable_execute,
    output logic             enable_writeback,
    output logic             enable_updatePC,
    output logic             br_taken,
    output logic [1:0]       mem_state,
`ifdef LC3_CTRL_STALL_CNT_EN
    output logic [CNT_W-1:0] stall_count,
`endif
    output logic             bypass_alu_1,
    output logic             bypass_alu_2,
    output logic             bypass_mem_1,
    output logic             bypass_mem_2
);

    localparam int c_wait_w = (CTRL_WAIT < 1) ? 1 : $clog2(CTRL_WAIT + 1);

    ctrl_state_t         r_state;
    mem_state_t          r_mem_state;
    logic [c_wait_w-1:0] r_cnt;
    logic                r_br_taken;
    logic                r_ind_store;
    logic                r_ctrl_jmp;

    logic w_run;
    logic w_mem;
    logic w_ctrl;
    logic w_fetch_ctrl;
    logic w_last_wait;
    logic w_br_decision;
    logic w_unused_imem;

    assign w_run  = (r_state == ST_RUN);
    assign w_mem  = (r_state == ST_MEM);
    assign w_ctrl = (r_state == ST_CTRL);

    assign w_fetch_ctrl  = w_run & complete_instr &
                           ((IMem_dout[15:12] == OP_BR) | (IMem_dout[15:12] == OP_JMP));
    assign w_last_wait   = w_ctrl & (r_cnt == c_wait_w'(1));
    assign w_br_decision = r_ctrl_jmp | (|(NZP & psr));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_mem_state <= MS_IDLE;
            r_cnt       <= '0;
            r_br_taken  <= 1'b0;
            r_ind_store <= 1'b0;
            r_ctrl_jmp  <= 1'b0;
        end else begin
            case (r_state)
                ST_MEM: begin
                    // The wait counter is frozen here; a pending control wait resumes afterwards.
                    if (complete_data) begin
                        if (r_mem_state == MS_IND) begin
                            r_mem_state <= r_ind_store ? MS_WRITE : MS_READ;
                        end else begin
                            r_mem_state <= MS_IDLE;
                            r_state     <= (r_cnt != '0) ? ST_CTRL : ST_RUN;
                        end
                    end
                end
                default: begin
                    if (w_ctrl) begin
                        r_cnt <= r_cnt - c_wait_w'(1);
                        if (w_last_wait) begin
                            r_br_taken <= w_br_decision;
                        end
                    end else if (w_fetch_ctrl) begin
                        r_cnt      <= c_wait_w'(CTRL_WAIT);
                        r_ctrl_jmp <= (IMem_dout[15:12] == OP_JMP);
                    end

                    if (is_mem_op(IR_Exec[15:12])) begin
                        r_state     <= ST_MEM;
                        r_mem_state <= first_mem_state(IR_Exec[15:12]);
                        r_ind_store <= (IR_Exec[15:12] == OP_STI);
                    end else if (w_last_wait) begin
                        r_state <= ST_RUN;
                    end else if (w_fetch_ctrl && (CTRL_WAIT > 0)) begin
                        r_state <= ST_CTRL;
                    end
                end
            endcase
        end
    end

    assign enable_fetch     = rst & w_run;
    assign enable_decode    = rst & ~w_mem;
    assign enable_execute   = rst & ~w_mem;
    assign enable_writeback = rst & (~w_mem | ((r_mem_state == MS_READ) & complete_data));
    assign enable_updatePC  = rst & ((w_run & complete_instr) | w_last_wait);
    assign mem_state        = r_mem_state;

    // The decision is presented live in its update cycle and held afterwards.
    assign br_taken = (rst & w_last_wait) ? w_br_decision : r_br_taken;

    lc3_hazard_detect u_hazard (
        .ir           (IR),
        .ir_exec      (IR_Exec),
        .active       (rst & w_run),
        .bypass_alu_1 (bypass_alu_1),
        .bypass_alu_2 (bypass_alu_2),
        .bypass_mem_1 (bypass_mem_1),
        .bypass_mem_2 (bypass_mem_2)
    );

`ifdef LC3_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (!enable_fetch && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    assign stall_count = r_stall_count;
`else
    logic [CNT_W-1:0] w_unused_stall;
    assign w_unused_stall = '0;
`endif

    assign w_unused_imem = ^IMem_dout[11:0];

endmodule
`default_nettype wire

// File: tb/tb_lc3_pipe_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc3_pipe_controller
//  Purpose  : Self-checking bench: directed sequences, bypass vector table
//             and randomized traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lc3_pipe_controller;

    localparam int CTRL_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        complete_instr, complete_data;
    logic [15:0] IMem_dout, IR, IR_Exec;
    logic [2:0]  NZP, psr;
    logic        enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC;
    logic        br_taken;
    logic [1:0]  mem_state;
    logic        bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2;
`ifdef LC3_CTRL_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    lc3_pipe_controller #(.CTRL_WAIT(CTRL_WAIT), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .complete_instr   (complete_instr),
        .complete_data    (complete_data),
        .IMem_dout        (IMem_dout),
        .IR               (IR),
        .IR_Exec          (IR_Exec),
        .NZP              (NZP),
        .psr              (psr),
        .enable_fetch     (enable_fetch),
        .enable_decode    (enable_decode),
        .enable_execute   (enable_execute),
        .enable_writeback (enable_writeback),
        .enable_updatePC  (enable_updatePC),
        .br_taken         (br_taken),
        .mem_state        (mem_state),
`ifdef LC3_CTRL_STALL_CNT_EN
        .stall_count      (stall_count),
`endif
        .bypass_alu_1     (bypass_alu_1),
        .bypass_alu_2     (bypass_alu_2),
        .bypass_mem_1     (bypass_mem_1),
        .bypass_mem_2     (bypass_mem_2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] ex;
        logic [3:0]  exp;
    } byp_vec_t;
    byp_vec_t bv [12];

    logic [1:0] ldi_ms [5] = '{2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    logic       ldi_cd [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0] ops    [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                                4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110};

    // Reference model: pending memory phases (spec mem_state codes) and control wait.
    int   mq [$];
    int   cw;
    bit   cjmp;
    bit   m_mem;
    int   m_ms;
    logic [6:0] e_outs;
    logic [3:0] e_byp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {enable_fetch, enable_decode, enable_execute, enable_writeback, enable_updatePC, mem_state};
    endfunction

    function automatic logic [3:0] byp();
        return {bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2};
    endfunction

    function automatic logic [3:0] byp_ref(input logic [15:0] ir, input logic [15:0] ex);
        logic [3:0] op  = ir[15:12];
        logic [3:0] xop = ex[15:12];
        bit reads1 = op inside {4'b0001, 4'b0101, 4'b1001, 4'b0110, 4'b0111, 4'b1100};
        bit reads2 = (op inside {4'b0001, 4'b0101}) && !ir[5];
        bit alu_p  = xop inside {4'b0001, 4'b0101, 4'b1001, 4'b1110};
        bit mem_p  = xop inside {4'b0010, 4'b0110, 4'b1010};
        bit h1 = reads1 && (ir[8:6] == ex[11:9]);
        bit h2 = reads2 && (ir[2:0] == ex[11:9]);
        return {h1 && alu_p, h2 && alu_p, h1 && mem_p, h2 && mem_p};
    endfunction

    function automatic logic [15:0] rand_instr(input bit ctrl_bias);
        logic [15:0] v = 16'($urandom);
        if (ctrl_bias && $urandom_range(0, 4) == 0)
            v[15:12] = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b1100;
        else
            v[15:12] = ops[$urandom_range(0, 11)];
        v[11:9] = 3'($urandom_range(0, 3));
        v[8:6]  = 3'($urandom_range(0, 3));
        v[2:0]  = 3'($urandom_range(0, 3));
        return v;
    endfunction

    task automatic model_edge();
        if (!rst) begin
            mq.delete();
            cw = 0;
        end else if (mq.size() != 0) begin
            if (complete_data) void'(mq.pop_front());
        end else begin
            if (cw > 0) cw--;
            else if (complete_instr && (IMem_dout[15:12] inside {4'b0000, 4'b1100})) begin
                cw   = CTRL_WAIT;
                cjmp = (IMem_dout[15:12] == 4'b1100);
            end
            case (IR_Exec[15:12])
                4'b0010, 4'b0110: mq.push_back(0);
                4'b0011, 4'b0111: mq.push_back(2);
                4'b1010: begin mq.push_back(1); mq.push_back(0); end
                4'b1011: begin mq.push_back(1); mq.push_back(2); end
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends at a negedge with the controller running.
    task automatic run_ctrl(input string nm, input logic [15:0] instr, input logic [2:0] nzp,
                            input logic [2:0] flags, input logic exp_br);
        IMem_dout = instr; complete_instr = 1'b1; NZP = nzp; psr = flags;
        #1;
        chk({nm, "_fetch"}, 32'(outs()), 32'(7'b11111_11));
        tick();
        complete_instr = 1'b0; IMem_dout = 16'h1000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("%s_wait%0d", nm, k), 32'(outs()),
                32'({4'b0111, (k == 2) ? 1'b1 : 1'b0, 2'b11}));
            if (k == 2) chk({nm, "_br"}, 32'(br_taken), 32'(exp_br));
            tick();
        end
        @(negedge clk);
        chk({nm, "_run"}, 32'(outs()), 32'(7'b11110_11));
    endtask

    initial begin
        bv[0]  = '{16'h18C3, 16'h16C1, 4'b1100};
        bv[1]  = '{16'h18C3, 16'h2600, 4'b0011};
        bv[2]  = '{16'h18E3, 16'h16C1, 4'b1000};
        bv[3]  = '{16'h3600, 16'h16C1, 4'b0000};
        bv[4]  = '{16'h7AC0, 16'h16C1, 4'b1000};
        bv[5]  = '{16'hC0C0, 16'h6600, 4'b0010};
        bv[6]  = '{16'h18C3, 16'h3600, 4'b0000};
        bv[7]  = '{16'h18C3, 16'hE600, 4'b1100};
        bv[8]  = '{16'h98FF, 16'hA600, 4'b0010};
        bv[9]  = '{16'h18C3, 16'h0600, 4'b0000};
        bv[10] = '{16'h1882, 16'h16C1, 4'b0000};
        bv[11] = '{16'h5883, 16'h2600, 4'b0001};

        rst = 1'b0; complete_instr = 1'b0; complete_data = 1'b0;
        IMem_dout = 16'h1000; IR = 16'h18C3; IR_Exec = 16'h16C1; NZP = 3'b000; psr = 3'b000;

        // Reset held, then released
        tick(); tick();
        @(negedge clk);
        chk("reset_outs", 32'(outs()), 32'(7'b00000_11));
        chk("reset_br", 32'(br_taken), 32'(0));
        chk("reset_byp", 32'(byp()), 32'(0));
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("run_ci0", 32'(outs()), 32'(7'b11110_11));
        chk("run_byp", 32'(byp()), 32'(4'b1100));
        complete_instr = 1'b1;
        #1;
        chk("run_ci1", 32'(outs()), 32'(7'b11111_11));
        complete_instr = 1'b0;

        // LDR with a three-cycle data access
        IR_Exec = 16'h6480;
        tick();
        IR_Exec = 16'h1000;
        for (int k = 0; k < 3; k++) begin
            complete_data = (k == 2);
            @(negedge clk);
            chk($sformatf("ldr_mem%0d", k), 32'(outs()),
                32'({3'b000, (k == 2) ? 1'b1 : 1'b0, 1'b0, 2'b00}));
            tick();
        end
        complete_data = 1'b0;
        @(negedge clk);
        chk("ldr_done", 32'(outs()), 32'(7'b11110_11));
`ifdef LC3_CTRL_STALL_CNT_EN
        chk("stall_count_ldr", 32'(stall_count), 32'(3));
`endif

        // LDI: indirect phase then read phase
        IR_Exec = 16'hA402;
        tick();
        IR_Exec = 16'h1000;
        for (int k = 0; k < 5; k++) begin
            complete_data = ldi_cd[k];
            @(negedge clk);
            chk($sformatf("ldi_mem%0d", k), 32'(outs()),
                32'({3'b000, (k == 4) ? 1'b1 : 1'b0, 1'b0, ldi_ms[k]}));
            tick();
        end
        complete_data = 1'b0;
        @(negedge clk);
        chk("ldi_done", 32'(outs()), 32'(7'b11110_11));

        // Control-flow waits
        run_ctrl("br_n_taken",  16'h0805, 3'b100, 3'b100, 1'b1);
        run_ctrl("br_n_not",    16'h0805, 3'b100, 3'b010, 1'b0);
        run_ctrl("jmp",         16'hC1C0, 3'b000, 3'b000, 1'b1);
        run_ctrl("br_nzp0",     16'h0005, 3'b000, 3'b111, 1'b0);

        // Bypass vectors
        foreach (bv[i]) begin
            IR = bv[i].ir; IR_Exec = bv[i].ex;
            #1;
            chk($sformatf("byp_vec%0d", i), 32'(byp()), 32'(bv[i].exp));
            IR_Exec = 16'h1000;
            tick();
            @(negedge clk);
        end

        // Store entering MEM together with a branch fetch
        IR_Exec = 16'h3600; IMem_dout = 16'h0E00; complete_instr = 1'b1; NZP = 3'b111; psr = 3'b001;
        tick();
        IR_Exec = 16'h1000; complete_instr = 1'b0; IMem_dout = 16'h1000;
        for (int k = 0; k < 2; k++) begin
            complete_data = (k == 1);
            @(negedge clk);
            chk($sformatf("sim_mem%0d", k), 32'(outs()), 32'(7'b00000_10));
            tick();
        end
        complete_data = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("sim_wait%0d", k), 32'(outs()),
                32'({4'b0111, (k == 2) ? 1'b1 : 1'b0, 2'b11}));
            if (k == 2) chk("sim_br", 32'(br_taken), 32'(1));
            tick();
        end
        @(negedge clk);
        chk("sim_run", 32'(outs()), 32'(7'b11110_11));

        // Reset during an indirect access
        IR_Exec = 16'hA402;
        tick();
        IR_Exec = 16'h1000;
        @(negedge clk);
        chk("rstmem_in", 32'(outs()), 32'(7'b00000_01));
        rst = 1'b0;
        #1;
        chk("rstmem_gated", 32'(outs()), 32'(7'b00000_01));
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmem_run", 32'(outs()), 32'(7'b11110_11));

        // Reset during a control wait
        IMem_dout = 16'h0805; complete_instr = 1'b1;
        tick();
        complete_instr = 1'b0; IMem_dout = 16'h1000;
        @(negedge clk);
        chk("rstctrl_in", 32'(outs()), 32'(7'b01110_11));
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rstctrl_run", 32'(outs()), 32'(7'b11110_11));

        // Randomized traffic against the reference model
        mq.delete(); cw = 0; cjmp = 1'b0;
        tick();
        for (int i = 0; i < 3000; i++) begin
            rst            = (i == 0) ? 1'b0 : ($urandom_range(0, 99) != 0);
            complete_instr = 1'($urandom);
            complete_data  = ($urandom_range(0, 9) < 3);
            IMem_dout      = rand_instr(1'b1);
            IR             = rand_instr(1'b0);
            IR_Exec        = rand_instr(1'b0);
            NZP            = 3'($urandom);
            psr            = 3'($urandom);
            @(negedge clk);
            m_mem  = (mq.size() != 0);
            m_ms   = m_mem ? mq[0] : 3;
            e_outs = {rst && !m_mem && cw == 0,
                      rst && !m_mem,
                      rst && !m_mem,
                      rst && (!m_mem || (m_ms == 0 && complete_data)),
                      rst && !m_mem && ((cw == 0) ? complete_instr : (cw == 1)),
                      2'(m_ms)};
            e_byp  = (rst && !m_mem && cw == 0) ? byp_ref(IR, IR_Exec) : 4'b0000;
            chk($sformatf("rand_outs[%0d]", i), 32'(outs()), 32'(e_outs));
            chk($sformatf("rand_byp[%0d]", i), 32'(byp()), 32'(e_byp));
            if (rst && !m_mem && cw == 1)
                chk($sformatf("rand_br[%0d]", i), 32'(br_taken), 32'(cjmp || (|(NZP & psr))));
            model_edge();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
